// File: rtl/qsn_pkg.sv
// qsn_pkg: shared helpers for the pipelined QSN shift-network controller.
//   qsn_shift_w    - width of a shift value for circulant size Z
//   qsn_col_w      - column index width (never below 1)
//   qsn_mod_sub    - (s - p) mod Z for operands already in 0..Z-1
//   qsn_merge_mask - merge-stage row mask for an effective shift e
package qsn_pkg;

    // Widest merge mask the decoder can produce; supports Z up to QSN_MASK_W + 1.
    localparam int unsigned QSN_MASK_W = 64;

    function automatic int unsigned qsn_shift_w(input int unsigned z);
        return (z > 2) ? $clog2(z) : 1;
    endfunction

    function automatic int unsigned qsn_col_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Operands are below z, so s + (z - p) stays below 2z: one bit above a shift value.
    function automatic int unsigned qsn_mod_sub(input int unsigned s, input int unsigned p,
                                                input int unsigned z);
        return (s >= p) ? (s - p) : (s + (z - p));
    endfunction

    // Row i takes the left-shifted copy while i < Z - e; a zero shift needs no merge.
    function automatic logic [QSN_MASK_W-1:0] qsn_merge_mask(input int unsigned e,
                                                             input int unsigned z);
        logic [QSN_MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < QSN_MASK_W; i++) begin
            m[i] = (e != 0) && (e < z) && (i < z - e);
        end
        return m;
    endfunction

endpackage

// File: rtl/qsn_sel_decode.sv
// qsn_sel_decode: combinational effective-shift to QSN select decoder.
//   i_eff       - effective cyclic shift, 0..Z-1
//   o_left_sel  - left shifter amount (equals i_eff)
//   o_right_sel - right shifter amount (Z - i_eff, or 0 for a zero shift)
//   o_merge_sel - per-row merge mask, Z-1 bits
module qsn_sel_decode
    import qsn_pkg::*;
#(
    parameter int unsigned PERMUTATION_LENGTH = 3,
    parameter int unsigned SHIFT_W            = qsn_shift_w(PERMUTATION_LENGTH)
) (
    input  logic [SHIFT_W-1:0]            i_eff,
    output logic [SHIFT_W-1:0]            o_left_sel,
    output logic [SHIFT_W-1:0]            o_right_sel,
    output logic [PERMUTATION_LENGTH-2:0] o_merge_sel
);

    assign o_left_sel  = i_eff;
    assign o_right_sel = (i_eff == '0) ? '0 : SHIFT_W'(PERMUTATION_LENGTH - 32'(i_eff));
    assign o_merge_sel = (PERMUTATION_LENGTH-1)'(qsn_merge_mask(32'(i_eff), PERMUTATION_LENGTH));

endmodule

// File: rtl/qsn_ctrl_pipe.sv
// qsn_ctrl_pipe: two-stage pipelined QSN controller for any circulant size Z.
// Turns a valid/ready stream of per-column shift requests into registered left/right/merge
// selects, optionally as differential shifts against the column's previously stored shift.
//   sys_clk, rstn             - clock, asynchronous active-low reset
//   mem_clr                   - synchronous clear of all stored shifts (frame start)
//   in_valid/in_ready         - request handshake
//   shift_factor, col_idx     - absolute shift and column of the request
//   diff_mode                 - 1: differential shift, 0: absolute shift
//   out_valid/out_ready       - select handshake
//   left_sel, right_sel       - shifter amounts
//   merge_sel                 - per-row merge mask (Z-1 bits)
//   eff_shift                 - effective shift behind the selects (debug)
//   range_err                 - sticky: a shift_factor >= Z was accepted
// Optional build macro QSN_CTRL_STALL_CNT_EN adds stall_cnt, a saturating 16-bit count of
// cycles with out_valid && !out_ready, cleared by reset and by mem_clr.
module qsn_ctrl_pipe
    import qsn_pkg::*;
#(
    parameter int unsigned PERMUTATION_LENGTH = 3,
    parameter int unsigned SHIFT_W            = qsn_shift_w(PERMUTATION_LENGTH),
    parameter int unsigned COL_NUM            = 4,
    parameter int unsigned COL_W              = qsn_col_w(COL_NUM)
) (
    input  logic                          sys_clk,
    input  logic                          rstn,
    input  logic                          mem_clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SHIFT_W-1:0]            shift_factor,
    input  logic [COL_W-1:0]              col_idx,
    input  logic                          diff_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SHIFT_W-1:0]            left_sel,
    output logic [SHIFT_W-1:0]            right_sel,
    output logic [PERMUTATION_LENGTH-2:0] merge_sel,
    output logic [SHIFT_W-1:0]            eff_shift,
    output logic                          range_err
`ifdef QSN_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int unsigned Z = PERMUTATION_LENGTH;

    logic               w_s2_en;
    logic               w_s1_en;
    logic               w_accept;
    logic               w_oob;
    logic               w_col_ok;
    logic [SHIFT_W-1:0] w_s;
    logic [SHIFT_W-1:0] w_p;
    logic [SHIFT_W-1:0] w_eff;
    logic [SHIFT_W-1:0] w_left;
    logic [SHIFT_W-1:0] w_right;
    logic [Z-2:0]       w_merge;

    logic [SHIFT_W-1:0] r_mem [COL_NUM];
    logic               r_s1_valid;
    logic [SHIFT_W-1:0] r_s1_eff;
    logic               r_out_valid;
    logic [SHIFT_W-1:0] r_left;
    logic [SHIFT_W-1:0] r_right;
    logic [Z-2:0]       r_merge;
    logic [SHIFT_W-1:0] r_eff;
    logic               r_range_err;

    // Handshake: each stage may load when the stage after it can take its contents.
    assign w_s2_en  = out_ready || !r_out_valid;
    assign w_s1_en  = w_s2_en || !r_s1_valid;
    assign in_ready = w_s1_en;
    assign w_accept = in_valid && w_s1_en;

    // Out-of-range shifts are replaced by 0, both for the datapath and the memory write.
    assign w_oob    = 32'(shift_factor) >= Z;
    assign w_s      = w_oob ? '0 : shift_factor;
    assign w_col_ok = 32'(col_idx) < COL_NUM;

    // A coincident mem_clr makes this request see a cleared column.
    always_comb begin
        w_p = '0;
        if (!mem_clr && w_col_ok) begin
            w_p = r_mem[col_idx];
        end
    end

    assign w_eff = diff_mode ? SHIFT_W'(qsn_mod_sub(32'(w_s), 32'(w_p), Z)) : w_s;

    // Shift memory: the accepted request's own write wins over a coincident clear.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < COL_NUM; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < COL_NUM; i++) begin
                if (w_accept && (32'(col_idx) == i)) begin
                    r_mem[i] <= w_s;
                end else if (mem_clr) begin
                    r_mem[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_eff   <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_eff <= w_eff;
            end
        end
    end

    qsn_sel_decode #(
        .PERMUTATION_LENGTH (Z),
        .SHIFT_W            (SHIFT_W)
    ) u_sel_decode (
        .i_eff       (r_s1_eff),
        .o_left_sel  (w_left),
        .o_right_sel (w_right),
        .o_merge_sel (w_merge)
    );

    // Output register; holds its data whenever the downstream stalls a valid beat.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_left      <= '0;
            r_right     <= '0;
            r_merge     <= '0;
            r_eff       <= '0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_left  <= w_left;
                r_right <= w_right;
                r_merge <= w_merge;
                r_eff   <= r_s1_eff;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_range_err <= 1'b0;
        end else if (w_accept && w_oob) begin
            r_range_err <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign left_sel  = r_left;
    assign right_sel = r_right;
    assign merge_sel = r_merge;
    assign eff_shift = r_eff;
    assign range_err = r_range_err;

`ifdef QSN_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (mem_clr) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_qsn_ctrl_pipe.sv
// Bench for qsn_ctrl_pipe: directed cases on a Z=3 instance, then a random stream on both a
// Z=3/4-column and a Z=7/8-column instance, all scored against a queue-based reference model.
`timescale 1ns/1ps
module tb_qsn_ctrl_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       in_valid  [2];
    logic       mem_clr   [2];
    logic       diff_mode [2];
    logic       out_ready [2];
    logic [2:0] sf        [2];
    logic [2:0] col       [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic       range_err [2];
    logic [2:0] left_a    [2];
    logic [2:0] right_a   [2];
    logic [2:0] eff_a     [2];
    logic [5:0] merge_a   [2];

    logic [1:0] left0, right0, eff0, merge0;
    logic [2:0] left1, right1, eff1;
    logic [5:0] merge1;

    int n_checks = 0;
    int n_fail   = 0;

    assign left_a[0]  = {1'b0, left0};
    assign right_a[0] = {1'b0, right0};
    assign eff_a[0]   = {1'b0, eff0};
    assign merge_a[0] = {4'b0, merge0};
    assign left_a[1]  = left1;
    assign right_a[1] = right1;
    assign eff_a[1]   = eff1;
    assign merge_a[1] = merge1;

`ifdef QSN_CTRL_STALL_CNT_EN
    logic [15:0] stall_a [2];
`endif

    qsn_ctrl_pipe #(
        .PERMUTATION_LENGTH (3),
        .COL_NUM            (4)
    ) u_dut3 (
        .sys_clk      (clk),
        .rstn         (rstn),
        .mem_clr      (mem_clr[0]),
        .in_valid     (in_valid[0]),
        .in_ready     (in_ready[0]),
        .shift_factor (sf[0][1:0]),
        .col_idx      (col[0][1:0]),
        .diff_mode    (diff_mode[0]),
        .out_valid    (out_valid[0]),
        .out_ready    (out_ready[0]),
        .left_sel     (left0),
        .right_sel    (right0),
        .merge_sel    (merge0),
        .eff_shift    (eff0),
        .range_err    (range_err[0])
`ifdef QSN_CTRL_STALL_CNT_EN
        ,
        .stall_cnt    (stall_a[0])
`endif
    );

    qsn_ctrl_pipe #(
        .PERMUTATION_LENGTH (7),
        .COL_NUM            (8)
    ) u_dut7 (
        .sys_clk      (clk),
        .rstn         (rstn),
        .mem_clr      (mem_clr[1]),
        .in_valid     (in_valid[1]),
        .in_ready     (in_ready[1]),
        .shift_factor (sf[1]),
        .col_idx      (col[1]),
        .diff_mode    (diff_mode[1]),
        .out_valid    (out_valid[1]),
        .out_ready    (out_ready[1]),
        .left_sel     (left1),
        .right_sel    (right1),
        .merge_sel    (merge1),
        .eff_shift    (eff1),
        .range_err    (range_err[1])
`ifdef QSN_CTRL_STALL_CNT_EN
        ,
        .stall_cnt    (stall_a[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int unsigned exp_right(input int unsigned e, input int unsigned z);
        return (e == 0) ? 0 : z - e;
    endfunction

    // Rows 0 .. Z-e-1 are set: a run of Z-e ones from bit 0.
    function automatic int unsigned exp_merge(input int unsigned e, input int unsigned z);
        return (e == 0) ? 0 : ((1 << (z - e)) - 1);
    endfunction

    // Reference model: one queue of expected effective shifts per DUT, evaluated on the
    // falling edge for the handshakes that complete at the next rising edge.
    for (genvar d = 0; d < 2; d++) begin : g_mon
        localparam int unsigned Z = (d == 0) ? 3 : 7;
        int unsigned mem [8];
        int unsigned exp_q [$];
        bit          err_m;
        int unsigned stall_m;
        bit          held;
        logic [2:0]  h_eff, h_left;
        int unsigned s, p, e;

        always @(negedge clk) begin
            if (!rstn) begin
                foreach (mem[i]) mem[i] = 0;
                exp_q.delete();
                err_m   = 0;
                stall_m = 0;
                held    = 0;
            end else begin
                check_eq($sformatf("d%0d_range_err", d), range_err[d], err_m);
                check_eq($sformatf("d%0d_in_ready", d), in_ready[d],
                         (exp_q.size() < 2) || out_ready[d]);
                if (exp_q.size() == 0) check_eq($sformatf("d%0d_idle_valid", d), out_valid[d], 0);
                if (exp_q.size() == 2) check_eq($sformatf("d%0d_full_valid", d), out_valid[d], 1);
                if (held) begin
                    check_eq($sformatf("d%0d_hold_valid", d), out_valid[d], 1);
                    check_eq($sformatf("d%0d_hold_eff", d), eff_a[d], h_eff);
                    check_eq($sformatf("d%0d_hold_left", d), left_a[d], h_left);
                end
`ifdef QSN_CTRL_STALL_CNT_EN
                check_eq($sformatf("d%0d_stall_cnt", d), stall_a[d], stall_m);
                if (mem_clr[d]) stall_m = 0;
                else if (out_valid[d] && !out_ready[d] && stall_m < 65535) stall_m++;
`endif
                if (out_valid[d] && out_ready[d] && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("d%0d_eff", d), eff_a[d], e);
                    check_eq($sformatf("d%0d_left", d), left_a[d], e);
                    check_eq($sformatf("d%0d_right", d), right_a[d], exp_right(e, Z));
                    check_eq($sformatf("d%0d_merge", d), merge_a[d], exp_merge(e, Z));
                end
                held   = out_valid[d] && !out_ready[d];
                h_eff  = eff_a[d];
                h_left = left_a[d];
                if (in_valid[d] && in_ready[d]) begin
                    s = (sf[d] < Z) ? sf[d] : 0;
                    if (sf[d] >= Z) err_m = 1;
                    p = mem_clr[d] ? 0 : mem[col[d]];
                    exp_q.push_back(diff_mode[d] ? (s + Z - p) % Z : s);
                    if (mem_clr[d]) foreach (mem[i]) mem[i] = 0;
                    mem[col[d]] = s;
                end else if (mem_clr[d]) begin
                    foreach (mem[i]) mem[i] = 0;
                end
            end
        end
    end

    task automatic drive(input int d, input bit v, input int unsigned s, input int unsigned c,
                         input bit dm, input bit clr);
        in_valid[d]  = v;
        sf[d]        = 3'(s);
        col[d]       = 3'(c);
        diff_mode[d] = dm;
        mem_clr[d]   = clr;
    endtask

    // Back-to-back requests into an empty Z=3 pipe with out_ready held high; item k must
    // appear two edges after it is presented, one per cycle.
    task automatic burst(input string tag, input int n, input int unsigned sh[8],
                         input int unsigned cl[8], input bit dm[8], input bit clr[8],
                         input int unsigned ex[8]);
        out_ready[0] = 1'b1;
        for (int k = 0; k <= n + 1; k++) begin
            if (k < n) begin
                drive(0, 1'b1, sh[k], cl[k], dm[k], clr[k]);
                #1 check_eq({tag, "_in_ready"}, in_ready[0], 1);
            end else begin
                drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
            end
            @(posedge clk);
            #1;
            if (k >= 1 && k <= n) begin
                check_eq($sformatf("%s_valid%0d", tag, k - 1), out_valid[0], 1);
                check_eq($sformatf("%s_eff%0d", tag, k - 1), eff_a[0], ex[k-1]);
                check_eq($sformatf("%s_left%0d", tag, k - 1), left_a[0], ex[k-1]);
                check_eq($sformatf("%s_right%0d", tag, k - 1), right_a[0], exp_right(ex[k-1], 3));
                check_eq($sformatf("%s_merge%0d", tag, k - 1), merge_a[0], exp_merge(ex[k-1], 3));
            end else if (k == n + 1) begin
                check_eq({tag, "_drained"}, out_valid[0], 0);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 0, 0, 1'b0, 1'b0);
            out_ready[d] = 1'b1;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst%0d_valid", d), out_valid[d], 0);
            check_eq($sformatf("rst%0d_left", d), left_a[d], 0);
            check_eq($sformatf("rst%0d_right", d), right_a[d], 0);
            check_eq($sformatf("rst%0d_merge", d), merge_a[d], 0);
            check_eq($sformatf("rst%0d_eff", d), eff_a[d], 0);
            check_eq($sformatf("rst%0d_range_err", d), range_err[d], 0);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Absolute shifts 0,1,2: selects (0,0,00), (1,2,11), (2,1,01).
        burst("abs", 3, '{0, 1, 2, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
              '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 1, 2, 0, 0, 0, 0, 0});

        // Stand-alone clear, then differential 2,1,1 on column 0; a final s=0 probes mem[0]=1.
        drive(0, 1'b0, 0, 0, 1'b0, 1'b1);
        @(posedge clk);
        #1 drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
        burst("diff", 4, '{2, 1, 1, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
              '{1, 1, 1, 1, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, '{2, 2, 0, 2, 0, 0, 0, 0});

        // Backpressure: a=2, b=1, c=0 with out_ready low across three edges.
        out_ready[0] = 1'b0;
        drive(0, 1'b1, 2, 1, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(0, 1'b1, 1, 2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("bp_ready_full", in_ready[0], 0);
        check_eq("bp_valid_a", out_valid[0], 1);
        check_eq("bp_eff_a", eff_a[0], 2);
        drive(0, 1'b1, 0, 3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("bp_ready_still", in_ready[0], 0);
        check_eq("bp_eff_a_held", eff_a[0], 2);
        out_ready[0] = 1'b1;
        #1 check_eq("bp_ready_release", in_ready[0], 1);
        @(posedge clk);
        #1 drive(0, 1'b0, 0, 0, 1'b0, 1'b0);
        check_eq("bp_eff_b", eff_a[0], 1);
        @(posedge clk);
        #1;
        check_eq("bp_valid_c", out_valid[0], 1);
        check_eq("bp_eff_c", eff_a[0], 0);
        @(posedge clk);
        #1 check_eq("bp_drained", out_valid[0], 0);

        // Out-of-range shift 3 acts as 0 and sets the sticky flag.
        check_eq("range_before", range_err[0], 0);
        burst("range", 2, '{3, 1, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0},
              '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0, 0, 0});
        repeat (3) @(posedge clk);
        #1 check_eq("range_sticky", range_err[0], 1);

        // Clear coincident with a col-1 differential request (prior mem[1]=1, mem[2]=2).
        burst("clr", 6, '{1, 2, 2, 0, 0, 1, 0, 0}, '{1, 2, 1, 1, 2, 0, 0, 0},
              '{0, 0, 1, 1, 1, 1, 0, 0}, '{0, 0, 1, 0, 0, 0, 0, 0}, '{1, 2, 2, 1, 0, 1, 0, 0});

        // Random stream on both instances with a reset dropped in mid-stream.
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc == 400) begin
                rstn = 1'b0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    check_eq($sformatf("midrst%0d_valid", d), out_valid[d], 0);
                    check_eq($sformatf("midrst%0d_range_err", d), range_err[d], 0);
                    drive(d, 1'b0, 0, 0, 1'b0, 1'b0);
                end
                @(posedge clk);
                #1 rstn = 1'b1;
            end
            for (int d = 0; d < 2; d++) begin
                drive(d, $urandom_range(0, 99) < 70, $urandom_range(0, (d == 0) ? 3 : 7),
                      $urandom_range(0, (d == 0) ? 3 : 7), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 19) == 0);
                out_ready[d] = $urandom_range(0, 99) < 65;
            end
            @(posedge clk);
            #1;
        end

        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 0, 0, 1'b0, 1'b0);
            out_ready[d] = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1;
        check_eq("drain3_pending", g_mon[0].exp_q.size(), 0);
        check_eq("drain7_pending", g_mon[1].exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
